// File: rtl/cache_sa_rd.sv
// Blocking set-associative read cache with true-LRU replacement and sequential flush.
// Optional hit/miss counters are built when CACHE_SA_STATS_EN is defined.
module cache_sa_rd #(
  parameter int SIZE_BLOCK = 32,
  parameter int BIT_TOTAL  = 24,
  parameter int BIT_INDEX  = 5,
  parameter int WAY        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [BIT_TOTAL-1:0]  i_addr,
  input  logic                  i_flush,
  output logic                  o_rsp_valid,
  output logic [SIZE_BLOCK-1:0] o_rsp_data,
  output logic                  o_rsp_hit,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [BIT_TOTAL-1:0]  o_mem_addr,
  input  logic                  i_mem_rsp_valid,
  input  logic [SIZE_BLOCK-1:0] i_mem_rsp_data
`ifdef CACHE_SA_STATS_EN
  ,
  output logic [31:0]           o_hit_cnt,
  output logic [31:0]           o_miss_cnt
`endif
);
  localparam int SETS    = 1 << BIT_INDEX;
  localparam int BIT_TAG = BIT_TOTAL - BIT_INDEX;
  localparam int AW      = (WAY > 1) ? $clog2(WAY) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_REQ, S_MISS_WAIT, S_FLUSH} state_t;

  state_t                            r_state;
  logic [BIT_TOTAL-1:0]              r_addr;
  logic [BIT_INDEX-1:0]              r_flush_idx;
  logic [SETS-1:0][WAY-1:0]          r_valid;
  logic [SETS-1:0][WAY-1:0][AW-1:0]  r_age;
  logic [BIT_TAG-1:0]                r_tag  [SETS][WAY];
  logic [SIZE_BLOCK-1:0]             r_data [SETS][WAY];
  logic                              r_rsp_valid;
  logic [SIZE_BLOCK-1:0]             r_rsp_data;

  logic [BIT_INDEX-1:0]  w_idx;
  logic [BIT_TAG-1:0]    w_tag;
  logic                  w_hit;
  logic [AW-1:0]         w_hit_way;
  logic [SIZE_BLOCK-1:0] w_hit_data;
  logic [AW-1:0]         w_vict;
  logic                  w_hit_rsp;
  logic                  w_fill;
  logic [AW-1:0]         w_acc_way;
  logic [AW-1:0]         w_acc_old;

  assign w_idx = r_addr[BIT_INDEX-1:0];
  assign w_tag = r_addr[BIT_TOTAL-1:BIT_INDEX];

  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_hit_data = '0;
    for (int w = 0; w < WAY; w++) begin
      if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
        w_hit      = 1'b1;
        w_hit_way  = AW'(w);
        w_hit_data = r_data[w_idx][w];
      end
    end
  end

  // Lowest invalid way wins; otherwise the oldest (lowest index on a tie).
  always_comb begin
    w_vict = '0;
    for (int w = WAY-1; w >= 0; w--)
      if (r_age[w_idx][w] == AW'(WAY-1)) w_vict = AW'(w);
    for (int w = WAY-1; w >= 0; w--)
      if (!r_valid[w_idx][w]) w_vict = AW'(w);
  end

  assign w_hit_rsp = (r_state == S_LOOKUP) && w_hit;
  assign w_fill    = (r_state == S_MISS_WAIT) && i_mem_rsp_valid;
  assign w_acc_way = w_hit_rsp ? w_hit_way : w_vict;
  // An invalid way counts as oldest so valid ways keep distinct, ordered ages.
  assign w_acc_old = r_valid[w_idx][w_acc_way] ? r_age[w_idx][w_acc_way] : AW'(WAY-1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_flush_idx <= '0;
      r_valid     <= '0;
      r_age       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      if (w_hit_rsp || w_fill) begin
        for (int w = 0; w < WAY; w++) begin
          if (w_acc_way == AW'(w))               r_age[w_idx][w] <= '0;
          else if (r_age[w_idx][w] < w_acc_old)  r_age[w_idx][w] <= r_age[w_idx][w] + AW'(1);
        end
      end
      case (r_state)
        S_IDLE: begin
          if (i_flush) begin
            r_state     <= S_FLUSH;
            r_flush_idx <= '0;
          end else if (i_req_valid) begin
            r_addr  <= i_addr;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP:   r_state <= w_hit ? S_IDLE : S_MISS_REQ;
        S_MISS_REQ: if (i_mem_req_ready) r_state <= S_MISS_WAIT;
        S_MISS_WAIT: begin
          if (i_mem_rsp_valid) begin
            r_valid[w_idx][w_vict] <= 1'b1;
            r_rsp_valid            <= 1'b1;
            r_rsp_data             <= i_mem_rsp_data;
            r_state                <= S_IDLE;
          end
        end
        S_FLUSH: begin
          r_valid[r_flush_idx] <= '0;
          r_age[r_flush_idx]   <= '0;
          r_flush_idx          <= r_flush_idx + BIT_INDEX'(1);
          if (r_flush_idx == {BIT_INDEX{1'b1}}) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_idx][w_vict] <= i_mem_rsp_data;
      r_tag[w_idx][w_vict]  <= w_tag;
    end
  end

`ifdef CACHE_SA_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else begin
      if (w_hit_rsp && o_hit_cnt != '1)  o_hit_cnt  <= o_hit_cnt + 32'd1;
      if (w_fill && o_miss_cnt != '1)    o_miss_cnt <= o_miss_cnt + 32'd1;
    end
  end
`endif

  assign o_req_ready     = rst_n && (r_state == S_IDLE) && !i_flush;
  assign o_rsp_valid     = w_hit_rsp | r_rsp_valid;
  assign o_rsp_hit       = w_hit_rsp;
  assign o_rsp_data      = w_hit_rsp ? w_hit_data : r_rsp_data;
  assign o_mem_req_valid = (r_state == S_MISS_REQ);
  assign o_mem_addr      = r_addr;
endmodule

// File: doc/cache_sa_rd.md
CACHE_SA_RD -- requirements
Module: cache_sa_rd

Interface
REQ-001 SHALL have parameter SIZE_BLOCK, default 32, meaning block/data width in bits.
REQ-002 SHALL have parameter BIT_TOTAL, default 24, meaning word-address width.
REQ-003 SHALL have parameter BIT_INDEX, default 5, meaning set-index width (2^BIT_INDEX sets).
REQ-004 SHALL have parameter WAY, default 2, meaning ways per set (power of two, 1..8).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk  in  1  rising-edge clock.
REQ-007 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port i_req_valid  in  1  lookup request.
REQ-009 SHALL have port o_req_ready  out  1  request accepted when valid&ready at clk edge.
REQ-010 SHALL have port i_addr  in  BIT_TOTAL  word address; index = i_addr[BIT_INDEX-1:0], tag = remaining upper bits.
REQ-011 SHALL have port i_flush  in  1  invalidate all lines.
REQ-012 SHALL have port o_rsp_valid  out  1  one-cycle response pulse.
REQ-013 SHALL have port o_rsp_data  out  SIZE_BLOCK  response data, 0 when o_rsp_valid=0.
REQ-014 SHALL have port o_rsp_hit  out  1  1=hit, 0=filled from memory; qualified by o_rsp_valid.
REQ-015 SHALL have ports o_mem_req_valid out 1, i_mem_req_ready in 1, o_mem_addr out BIT_TOTAL: fill request.
REQ-016 SHALL have ports i_mem_rsp_valid in 1, i_mem_rsp_data in SIZE_BLOCK: fill data.

Function
REQ-017 SHALL implement FSM IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FLUSH; o_req_ready=1 only in IDLE with i_flush=0.
REQ-018 IDLE: i_flush=1 -> FLUSH (flush wins over simultaneous request); else accepted request -> LOOKUP with address registered.
REQ-019 LOOKUP: compare tag against all valid ways of the set; hit -> o_rsp_valid=1, o_rsp_hit=1, data of hit way in that cycle, update LRU, -> IDLE (hit latency 1 cycle after acceptance).
REQ-020 LOOKUP miss -> MISS_REQ; o_mem_req_valid=1, o_mem_addr=registered address, held stable until i_mem_req_ready=1 -> MISS_WAIT.
REQ-021 MISS_WAIT: on i_mem_rsp_valid, write data and tag to victim way, set valid, mark MRU, and present o_rsp_valid=1, o_rsp_hit=0, o_rsp_data=fill data in the following cycle, then IDLE.
REQ-022 Victim SHALL be lowest-numbered invalid way; if all valid, the least-recently-used way (true LRU, log2(WAY)-bit age per way; WAY=1 always way 0).
REQ-023 LRU update: accessed way age=0; ways younger than it increment; others unchanged.
REQ-024 FLUSH: clear valid bits and ages of one set per cycle, index 0..2^BIT_INDEX-1, then IDLE; i_flush ignored outside IDLE.
REQ-025 i_mem_rsp_valid outside MISS_WAIT SHALL be ignored; i_req_valid while not ready SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, all valid bits and ages 0, o_req_ready=0 during reset, o_rsp_valid=0, o_rsp_data=0, o_mem_req_valid=0, o_mem_addr=0; data/tag arrays not reset.
REQ-027 Reset mid-miss or mid-flush SHALL abandon the operation; a later memory response SHALL be ignored.

Configuration
REQ-028 With macro CACHE_SA_STATS_EN defined, SHALL add outputs o_hit_cnt and o_miss_cnt (32 bits each, reset 0, +1 per hit/miss response, saturating at all-ones, not cleared by flush); without it these ports and counters SHALL not exist.

Verification
REQ-029 Cold read 0x000003, memory returns 0xA -> one mem request to 0x000003, response hit=0 data 0xA; reread -> hit=1 data 0xA one cycle after acceptance.
REQ-030 WAY=2: fill 0x000000, 0x000020, read 0x000000, fill 0x000040 -> 0x000020 evicted; reading 0x000020 misses, 0x000000 hits.
REQ-031 i_flush and i_req_valid asserted together in IDLE -> 32 flush cycles with o_req_ready=0; subsequent read of 0x000003 misses.
REQ-032 i_mem_req_ready held 0 for 5 cycles -> o_mem_req_valid and o_mem_addr stable throughout; response arrives only after handshake.
REQ-033 rst_n low during MISS_WAIT, then stray i_mem_rsp_valid -> no o_rsp_valid; all lines invalid.
REQ-034 With CACHE_SA_STATS_EN: 3 hits, 2 misses -> o_hit_cnt=3, o_miss_cnt=2.
